// File: rtl/memory_port_arbiter.sv
// Purpose : shares one single-ported unified memory between the MIPS fetch port and data port.
// Latency : 2 edges from request sampling to done with a zero-wait memory, 1 edge for an address error,
//           TIMEOUT+1 edges on a memory timeout.
// Backpres: requests are held until their done pulse; memReady stretches ACCESS up to TIMEOUT cycles.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration between fetch and data.
// Without it, data always wins over fetch.
//
// Ports:
//   clock, resetN                       - rising-edge clock, asynchronous active-low reset
//   insReq/insAddress                   - fetch request (held until insDone) and byte address
//   insReadValue/insDone                - fetched word and one-cycle completion pulse
//   dataRead/dataWrite/dataAddress      - data request (held until dataDone) and byte address
//   dataWriteValue                      - store word
//   dataReadValue/dataDone              - load word and one-cycle completion pulse
//   addrError/errorAddress              - error pulse (with done) and byte address of the last failure
//   memReq/memWrite/memAddress          - memory strobe, write select, word index
//   memWriteValue/memReadValue/memReady - memory write data, read data, completion
module memory_port_arbiter #(
    parameter logic [31:0] TEXT_BASE = 32'h00400000,
    parameter logic [31:0] DATA_BASE = 32'h10010000,
    parameter int          SEG_WORDS = 1024,
    parameter int          ADDR_W    = 11,
    parameter int          TIMEOUT   = 15
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              insReq,
    input  logic [31:0]       insAddress,
    output logic [31:0]       insReadValue,
    output logic              insDone,
    input  logic              dataRead,
    input  logic              dataWrite,
    input  logic [31:0]       dataAddress,
    input  logic [31:0]       dataWriteValue,
    output logic [31:0]       dataReadValue,
    output logic              dataDone,
    output logic              addrError,
    output logic [31:0]       errorAddress,
    output logic              memReq,
    output logic              memWrite,
    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memWriteValue,
    input  logic [31:0]       memReadValue,
    input  logic              memReady
);

    localparam logic [31:0] SEG_BYTES = 32'(SEG_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    state_t            stateNext;

    logic              dataPend;
    logic              grantData;
    logic              grantAny;
    logic [31:0]       reqAddress;
    logic [31:0]       segBase;
    logic [31:0]       segOffset;
    logic              addrOk;
    logic [ADDR_W-1:0] wordIdx;
    logic              timeoutHit;

    logic [7:0]        waitCnt;
    logic              servingData;
    logic              errFlag;
    logic [31:0]       curAddress;

    assign dataPend = dataRead | dataWrite;

`ifdef ARB_ROUND_ROBIN_EN
    // preferData is the round-robin pointer: it names the side that wins a tie.
    logic preferData;

    assign grantData = dataPend & (~insReq | preferData);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            preferData <= 1'b1;
        end else if (state == IDLE && grantAny) begin
            preferData <= ~grantData;
        end
    end
`else
    assign grantData = dataPend;
`endif

    assign grantAny   = dataPend | insReq;
    assign reqAddress = grantData ? dataAddress : insAddress;
    assign segBase    = grantData ? DATA_BASE : TEXT_BASE;

    // Unsigned subtract: an address below its segment base wraps to a huge
    // offset and therefore fails the range check as well.
    assign segOffset  = reqAddress - segBase;
    assign addrOk     = (reqAddress[1:0] == 2'b00) && (segOffset < SEG_BYTES);

    // Data words live directly above the text words in the unified memory.
    assign wordIdx    = ADDR_W'(segOffset[31:2]) + (grantData ? ADDR_W'(SEG_WORDS) : '0);

    // The counter holds the number of ACCESS cycles already spent without
    // memReady, so the abort happens in the TIMEOUT-th ACCESS cycle.
    assign timeoutHit = (waitCnt == 8'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantAny) begin
                    stateNext = addrOk ? ACCESS : RESP;
                end
            end
            ACCESS: begin
                if (memReady || timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                // Requests are deliberately ignored here so the served
                // requester has one edge to drop its request.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign memReq    = (state == ACCESS);
    assign insDone   = (state == RESP) && !servingData;
    assign dataDone  = (state == RESP) && servingData;
    assign addrError = (state == RESP) && errFlag;

    // Access bookkeeping and datapath registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            waitCnt       <= '0;
            servingData   <= 1'b0;
            errFlag       <= 1'b0;
            curAddress    <= '0;
            errorAddress  <= '0;
            memAddress    <= '0;
            memWrite      <= 1'b0;
            memWriteValue <= '0;
            insReadValue  <= '0;
            dataReadValue <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantAny) begin
                        servingData <= grantData;
                        curAddress  <= reqAddress;
                        waitCnt     <= '0;
                        if (addrOk) begin
                            errFlag    <= 1'b0;
                            memAddress <= wordIdx;
                            // A simultaneous read+write request is served as a write.
                            memWrite   <= grantData & dataWrite;
                            if (grantData && dataWrite) begin
                                memWriteValue <= dataWriteValue;
                            end
                        end else begin
                            errFlag      <= 1'b1;
                            errorAddress <= reqAddress;
                        end
                    end
                end
                ACCESS: begin
                    if (memReady) begin
                        if (!memWrite) begin
                            if (servingData) begin
                                dataReadValue <= memReadValue;
                            end else begin
                                insReadValue <= memReadValue;
                            end
                        end
                    end else if (timeoutHit) begin
                        errFlag      <= 1'b1;
                        errorAddress <= curAddress;
                    end else begin
                        waitCnt <= waitCnt + 8'd1;
                    end
                end
                RESP: begin
                    waitCnt <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Purpose : self-checking bench for memory_port_arbiter with a behavioural memory model.
// Latency : expectations carry the number of edges from request drive to done.
// Backpres: the memory model inserts a programmable number of memReady wait cycles.
module tb_memory_port_arbiter;

    localparam int ADDR_W = 11;

    logic              clock = 1'b0;
    logic              resetN;
    logic              insReq;
    logic [31:0]       insAddress;
    logic [31:0]       insReadValue;
    logic              insDone;
    logic              dataRead;
    logic              dataWrite;
    logic [31:0]       dataAddress;
    logic [31:0]       dataWriteValue;
    logic [31:0]       dataReadValue;
    logic              dataDone;
    logic              addrError;
    logic [31:0]       errorAddress;
    logic              memReq;
    logic              memWrite;
    logic [ADDR_W-1:0] memAddress;
    logic [31:0]       memWriteValue;
    logic [31:0]       memReadValue = '0;
    logic              memReady = 1'b0;

    memory_port_arbiter dut (
        .clock          (clock),
        .resetN         (resetN),
        .insReq         (insReq),
        .insAddress     (insAddress),
        .insReadValue   (insReadValue),
        .insDone        (insDone),
        .dataRead       (dataRead),
        .dataWrite      (dataWrite),
        .dataAddress    (dataAddress),
        .dataWriteValue (dataWriteValue),
        .dataReadValue  (dataReadValue),
        .dataDone       (dataDone),
        .addrError      (addrError),
        .errorAddress   (errorAddress),
        .memReq         (memReq),
        .memWrite       (memWrite),
        .memAddress     (memAddress),
        .memWriteValue  (memWriteValue),
        .memReadValue   (memReadValue),
        .memReady       (memReady)
    );

    always #5 clock = ~clock;

    // Memory model: word i starts as 0x5A000000+i; readyDelay wait cycles per access.
    int          readyDelay = 0;
    int          memWaitCnt = 0;
    bit          memLoaded  = 1'b0;
    logic [31:0] memArr [0:(1<<ADDR_W)-1];

    always @(negedge clock) begin
        if (!memLoaded) begin
            for (int i = 0; i < (1 << ADDR_W); i++) begin
                memArr[i] = 32'h5A000000 + 32'(i);
            end
            memLoaded = 1'b1;
        end
        if (memReady) begin
            // The access completed on the previous rising edge.
            if (memWrite) begin
                memArr[memAddress] = memWriteValue;
            end
            memReady   = 1'b0;
            memWaitCnt = 0;
        end else if (memReq) begin
            if (memWaitCnt >= readyDelay) begin
                memReady     = 1'b1;
                memReadValue = memArr[memAddress];
            end else begin
                memWaitCnt++;
            end
        end else begin
            memWaitCnt = 0;
        end
    end

    // Memory-side monitor: counts strobe cycles and records the presented access.
    int                reqCnt   = 0;
    logic [ADDR_W-1:0] seenAddr = '0;
    logic              seenWr   = 1'b0;
    logic [31:0]       seenWdat = '0;

    always @(posedge clock) begin
        if (memReq) begin
            reqCnt++;
            seenAddr = memAddress;
            seenWr   = memWrite;
            seenWdat = memWriteValue;
        end
    end

    typedef struct {
        bit          isData;
        bit          err;
        logic [31:0] rd;
        logic [31:0] errAddr;
        logic [31:0] idx;
        bit          wr;
        logic [31:0] wdat;
        int          reqCycles;
        int          lat;
    } exp_t;

    exp_t        expQ[$];
    int          tests    = 0;
    int          failures = 0;
    logic [31:0] lastErr  = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic pushExp(input bit isData, input bit err, input logic [31:0] rd,
                           input logic [31:0] errAddr, input logic [31:0] idx, input bit wr,
                           input logic [31:0] wdat, input int reqCycles, input int lat);
        exp_t e;
        e.isData    = isData;
        e.err       = err;
        e.rd        = rd;
        e.errAddr   = errAddr;
        e.idx       = idx;
        e.wr        = wr;
        e.wdat      = wdat;
        e.reqCycles = reqCycles;
        e.lat       = lat;
        expQ.push_back(e);
    endtask

    // Waits (bounded) for the next done pulse and compares it with the head of the queue.
    task automatic waitDone(input string tag);
        exp_t e;
        int   edges;
        int   reqBase;
        bit   got;
        e       = expQ.pop_front();
        reqBase = reqCnt;
        edges   = 0;
        got     = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clock);
            #1;
            edges++;
            if (insDone || dataDone) got = 1'b1;
        end
        check({tag, ".done_seen"}, 32'(got), 32'd1);
        if (got) begin
            check({tag, ".done_port"}, 32'({insDone, dataDone}), e.isData ? 32'd1 : 32'd2);
            check({tag, ".addr_error"}, 32'(addrError), 32'(e.err));
            check({tag, ".latency"}, 32'(edges), 32'(e.lat));
            check({tag, ".mem_cycles"}, 32'(reqCnt - reqBase), 32'(e.reqCycles));
            if (e.err) begin
                lastErr = e.errAddr;
                check({tag, ".error_address"}, errorAddress, e.errAddr);
            end else begin
                check({tag, ".error_address_held"}, errorAddress, lastErr);
                check({tag, ".mem_address"}, 32'(seenAddr), e.idx);
                check({tag, ".mem_write"}, 32'(seenWr), 32'(e.wr));
                if (e.wr) begin
                    check({tag, ".mem_write_value"}, seenWdat, e.wdat);
                end else begin
                    check({tag, ".read_value"}, e.isData ? dataReadValue : insReadValue, e.rd);
                end
            end
            if (e.isData) begin
                dataRead  = 1'b0;
                dataWrite = 1'b0;
            end else begin
                insReq = 1'b0;
            end
            @(posedge clock);
            #1;
            check({tag, ".pulse_width"}, 32'({insDone, dataDone, addrError}), 32'd0);
        end
    endtask

    initial begin
        resetN         = 1'b0;
        insReq         = 1'b0;
        insAddress     = '0;
        dataRead       = 1'b0;
        dataWrite      = 1'b0;
        dataAddress    = '0;
        dataWriteValue = '0;

        repeat (2) @(posedge clock);
        #1;
        check("reset.strobes", 32'({insDone, dataDone, addrError, memReq, memWrite}), 32'd0);
        check("reset.error_address", errorAddress, 32'd0);
        check("reset.mem_address", 32'(memAddress), 32'd0);
        check("reset.read_values", insReadValue | dataReadValue, 32'd0);
        resetN = 1'b1;
        @(posedge clock);
        #1;

        // Fetch, zero wait
        pushExp(0, 0, 32'h5A000002, 0, 2, 0, 0, 1, 2);
        insAddress = 32'h00400008;
        insReq     = 1'b1;
        waitDone("fetch0");

        // Store then load in the data segment
        pushExp(1, 0, 0, 0, 1029, 1, 32'hDEADBEEF, 1, 2);
        dataAddress    = 32'h10010014;
        dataWriteValue = 32'hDEADBEEF;
        dataWrite      = 1'b1;
        waitDone("store");

        pushExp(1, 0, 32'hDEADBEEF, 0, 1029, 0, 0, 1, 2);
        dataAddress = 32'h10010014;
        dataRead    = 1'b1;
        waitDone("load");

        // Simultaneous requests; the last grant was data
`ifdef ARB_ROUND_ROBIN_EN
        pushExp(0, 0, 32'h5A000003, 0, 3, 0, 0, 1, 2);
        pushExp(1, 0, 32'hDEADBEEF, 0, 1029, 0, 0, 1, 2);
`else
        pushExp(1, 0, 32'hDEADBEEF, 0, 1029, 0, 0, 1, 2);
        pushExp(0, 0, 32'h5A000003, 0, 3, 0, 0, 1, 2);
`endif
        insAddress  = 32'h0040000C;
        insReq      = 1'b1;
        dataAddress = 32'h10010014;
        dataRead    = 1'b1;
        waitDone("both.first");
        waitDone("both.second");

        // Misaligned data read
        pushExp(1, 1, 0, 32'h10010002, 0, 0, 0, 0, 1);
        dataAddress = 32'h10010002;
        dataRead    = 1'b1;
        waitDone("misaligned");

        // Fetch one past the end of the text segment
        pushExp(0, 1, 0, 32'h00401000, 0, 0, 0, 0, 1);
        insAddress = 32'h00401000;
        insReq     = 1'b1;
        waitDone("out_of_segment");

        // Data access below its segment base wraps and is rejected
        pushExp(1, 1, 0, 32'h1000FFFC, 0, 0, 0, 0, 1);
        dataAddress = 32'h1000FFFC;
        dataRead    = 1'b1;
        waitDone("below_base");

        // Timeout: memReady never arrives
        readyDelay = 1000;
        pushExp(0, 1, 0, 32'h00400010, 0, 0, 0, 15, 16);
        insAddress = 32'h00400010;
        insReq     = 1'b1;
        waitDone("timeout");
        check("timeout.idle_after", 32'(memReq), 32'd0);

        // Two memReady wait cycles
        readyDelay = 2;
        pushExp(0, 0, 32'h5A000005, 0, 5, 0, 0, 3, 4);
        insAddress = 32'h00400014;
        insReq     = 1'b1;
        waitDone("wait2");

        // Reset during ACCESS
        readyDelay = 1000;
        insAddress = 32'h00400020;
        insReq     = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("midreset.in_access", 32'(memReq), 32'd1);
        resetN = 1'b0;
        #1;
        check("midreset.strobes", 32'({insDone, dataDone, addrError, memReq, memWrite}), 32'd0);
        check("midreset.error_address", errorAddress, 32'd0);
        check("midreset.read_values", insReadValue | dataReadValue, 32'd0);
        check("midreset.mem_address", 32'(memAddress), 32'd0);
        check("midreset.mem_write_value", memWriteValue, 32'd0);
        insReq     = 1'b0;
        readyDelay = 0;
        lastErr    = '0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        @(posedge clock);
        #1;

        // Fresh fetch after reset release
        pushExp(0, 0, 32'h5A000001, 0, 1, 0, 0, 1, 2);
        insAddress = 32'h00400004;
        insReq     = 1'b1;
        waitDone("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
